// File: rtl/alu_issue_ctrl.sv
// ALU issue/capture controller: decodes ALUOp/Funct3/Funct7, drives the ALU
// for one cycle, then holds the result and branch-taken flag until accepted.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     use_imm,
    input  logic [DATA_WIDTH-1:0]    rs1_val,
    input  logic [DATA_WIDTH-1:0]    rs2_val,
    input  logic [DATA_WIDTH-1:0]    imm,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_result,
    output logic                     out_taken,
    output logic                     out_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND =
        OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR =
        OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD =
        OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  =
        OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB =
        OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  =
        OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = '1;

    state_t state;

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_br;
    logic                     dec_inv;
    logic                     dec_ill;
    logic                     br_q;
    logic                     inv_q;
    logic                     ill_q;
    logic                     accept;

    assign in_ready = (state == IDLE) |
                      ((state == HOLD) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        dec_op  = OP_ILL;
        dec_br  = 1'b0;
        dec_inv = 1'b0;
        dec_ill = 1'b0;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                dec_br = 1'b1;
                case (Funct3)
                    3'b000: dec_op = OP_EQ;
                    3'b001: begin
                        dec_op  = OP_EQ;
                        dec_inv = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                case (Funct3)
                    3'b000: begin
                        // Only the register form can subtract.
                        if (!use_imm &&
                            Funct7 == 7'b0100000)
                            dec_op = OP_SUB;
                        else
                            dec_op = OP_ADD;
                    end
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill)
            dec_op = OP_ILL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            alu_srca    <= '0;
            alu_srcb    <= '0;
            alu_op      <= '0;
            br_q        <= 1'b0;
            inv_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_result  <= '0;
            out_valid   <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (accept) begin
                alu_srca <= rs1_val;
                alu_srcb <= use_imm ? imm : rs2_val;
                alu_op   <= dec_op;
                br_q     <= dec_br & ~dec_ill;
                inv_q    <= dec_inv;
                ill_q    <= dec_ill;
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= EXEC;
                end
                EXEC: begin
                    out_result  <= ill_q ? '0 : alu_result;
                    out_taken   <= br_q &
                                   (alu_result[0] ^ inv_q);
                    out_illegal <= ill_q;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        use_imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_taken;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUOp(ALUOp),
        .Funct3(Funct3),
        .Funct7(Funct7),
        .use_imm(use_imm),
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .imm(imm),
        .alu_srca(alu_srca),
        .alu_srcb(alu_srcb),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_taken(out_taken),
        .out_illegal(out_illegal)
    );

    // Datapath ALU; unknown codes return junk so masking is observable.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_srca & alu_srcb;
            4'b0001: alu_result = alu_srca ^ alu_srcb;
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0011: alu_result = alu_srca | alu_srcb;
            4'b0100: alu_result = alu_srca - alu_srcb;
            4'b1000: alu_result = {31'd0, alu_srca == alu_srcb};
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic ui,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        ALUOp   = op;
        Funct3  = f3;
        Funct7  = f7;
        use_imm = ui;
        rs1_val = a;
        rs2_val = b;
        imm     = im;
    endtask

    // Present at a negedge, accept at the next posedge (E0).
    task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic ui,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        drive(op, f3, f7, ui, a, b, im);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drive(2'b11, 3'b111, 7'h7F, 1'b0, '1, '1, '1);
    endtask

    task automatic to_hold();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 1'b0, '0, '0, '0);
        #12;
        checks++;
        if ({alu_srca, alu_srcb, alu_op, out_result} !== 100'd0 ||
            {out_valid, out_taken, out_illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: srca=%h srcb=%h op=%b res=%h v=%b t=%b i=%b",
                     alu_srca, alu_srcb, alu_op, out_result,
                     out_valid, out_taken, out_illegal);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        issue(2'b10, 3'b000, 7'h00, 1'b1, 32'd5, 32'd99, 32'hFFFFFFFF);
        checks++;
        if (alu_op !== 4'b0010 || out_valid !== 1'b0 ||
            in_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: op=%b v=%b rdy=%b want 0010 0 0",
                     alu_op, out_valid, in_ready);
        end
        to_hold();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd4 ||
            out_taken !== 1'b0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_hold: v=%b res=%h t=%b i=%b want 1 4 0 0",
                     out_valid, out_result, out_taken, out_illegal);
        end
        ack();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_sub_addi();
        issue(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd3, 32'd5, 32'd77);
        checks++;
        if (alu_op !== 4'b0100) begin
            errors++;
            $display("FAIL sub_op: got %b want 0100", alu_op);
        end
        to_hold();
        checks++;
        if (out_result !== 32'hFFFFFFFE || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_res: got %h v=%b want fffffffe 1",
                     out_result, out_valid);
        end
        ack();
        issue(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd3, 32'd77, 32'd5);
        checks++;
        if (alu_op !== 4'b0010 || alu_srcb !== 32'd5) begin
            errors++;
            $display("FAIL addi_op: op=%b srcb=%h want 0010 5",
                     alu_op, alu_srcb);
        end
        to_hold();
        checks++;
        if (out_result !== 32'd8) begin
            errors++;
            $display("FAIL addi_res: got %h want 8", out_result);
        end
        ack();
    endtask

    task automatic test_branch();
        issue(2'b01, 3'b000, 7'h00, 1'b0, 32'd7, 32'd7, 32'd0);
        checks++;
        if (alu_op !== 4'b1000) begin
            errors++;
            $display("FAIL beq_op: got %b want 1000", alu_op);
        end
        to_hold();
        checks++;
        if (out_taken !== 1'b1 || out_result !== 32'd1) begin
            errors++;
            $display("FAIL beq_taken: t=%b res=%h want 1 1",
                     out_taken, out_result);
        end
        ack();
        issue(2'b01, 3'b001, 7'h00, 1'b0, 32'd7, 32'd7, 32'd0);
        to_hold();
        checks++;
        if (out_taken !== 1'b0 || out_result !== 32'd1 ||
            out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL bne_taken: t=%b res=%h i=%b want 0 1 0",
                     out_taken, out_result, out_illegal);
        end
        ack();
        issue(2'b01, 3'b001, 7'h00, 1'b0, 32'd7, 32'd8, 32'd0);
        to_hold();
        checks++;
        if (out_taken !== 1'b1 || out_result !== 32'd0) begin
            errors++;
            $display("FAIL bne_diff: t=%b res=%h want 1 0",
                     out_taken, out_result);
        end
        ack();
    endtask

    task automatic test_illegal();
        issue(2'b10, 3'b001, 7'h00, 1'b0, 32'd5, 32'd5, 32'd0);
        checks++;
        if (alu_op !== 4'b1111) begin
            errors++;
            $display("FAIL ill_f3_op: got %b want 1111", alu_op);
        end
        to_hold();
        checks++;
        if (out_illegal !== 1'b1 || out_result !== 32'd0 ||
            out_taken !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ill_f3: i=%b res=%h t=%b v=%b want 1 0 0 1",
                     out_illegal, out_result, out_taken, out_valid);
        end
        ack();
        issue(2'b11, 3'b000, 7'h00, 1'b0, 32'd5, 32'd5, 32'd0);
        checks++;
        if (alu_op !== 4'b1111) begin
            errors++;
            $display("FAIL ill_op11_op: got %b want 1111", alu_op);
        end
        to_hold();
        checks++;
        if (out_illegal !== 1'b1 || out_result !== 32'd0 ||
            out_taken !== 1'b0) begin
            errors++;
            $display("FAIL ill_op11: i=%b res=%h t=%b want 1 0 0",
                     out_illegal, out_result, out_taken);
        end
        ack();
        issue(2'b01, 3'b100, 7'h00, 1'b0, 32'd4, 32'd4, 32'd0);
        to_hold();
        checks++;
        if (out_illegal !== 1'b1 || out_taken !== 1'b0) begin
            errors++;
            $display("FAIL ill_branch: i=%b t=%b want 1 0",
                     out_illegal, out_taken);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        issue(2'b00, 3'b000, 7'h00, 1'b0, 32'd1, 32'd2, 32'd0);
        to_hold();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            drive(2'b10, 3'b100, 7'h00, i[1], 32'(i * 13),
                  32'(i + 9), 32'hA5A5_0000);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd3 ||
                in_ready !== 1'b0 || out_taken !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b res=%h rdy=%b t=%b want 1 3 0 0",
                         i, out_valid, out_result, in_ready, out_taken);
            end
        end
        drive(2'b10, 3'b100, 7'h00, 1'b0, 32'hF0, 32'hFF, 32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || alu_op !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_exec: v=%b op=%b want 0 0001",
                     out_valid, alu_op);
        end
        to_hold();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0F) begin
            errors++;
            $display("FAIL b2b_res: v=%b res=%h want 1 0f",
                     out_valid, out_result);
        end
        ack();
    endtask

    task automatic test_reset_exec();
        issue(2'b10, 3'b110, 7'h00, 1'b0, 32'h30, 32'h03, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({alu_srca, alu_srcb, alu_op, out_result} !== 100'd0 ||
            {out_valid, out_taken, out_illegal} !== 3'b000) begin
            errors++;
            $display("FAIL rst_exec: srca=%h srcb=%h op=%b res=%h v=%b",
                     alu_srca, alu_srcb, alu_op, out_result, out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: v=%b want 0",
                         i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_addi();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
